// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch
// Instruction memory for the IF stage of the MIPS pipeline. Holds DEPTH
// instruction words that are filled by a sequential program loader and then
// read with a registered, one-cycle fetch.
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   req, addr   - fetch request and byte address (word aligned, < 4*DEPTH)
//   stall       - holds instr/valid/fault and blocks new requests
//   instr       - fetched instruction, NOP_INSTR when nothing valid is held
//   valid       - instr/fault hold a completed fetch
//   fault       - completed fetch was misaligned or out of range
//   load_start  - enter (or restart) LOAD mode, pointer cleared to 0
//   load_valid  - write load_data at the pointer and advance it
//   load_data   - program word
//   load_done   - leave LOAD mode
//   loading     - high while in LOAD mode
//   load_count  - words written since the last load_start
module instr_mem_fetch #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       stall,
    output logic [DATA_W-1:0]          instr,
    output logic                       valid,
    output logic                       fault,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_done,
    output logic                       loading,
    output logic [$clog2(DEPTH):0]     load_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     count_nx;
    logic [DATA_W-1:0] instr_nx;
    logic              valid_nx;
    logic              fault_nx;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]     fetch_idx;
    logic              misaligned;
    logic              out_of_range;

    assign fetch_idx    = addr[IW+1:2];
    assign misaligned   = |addr[1:0];
    // Any set bit above the word-index field means addr >= 4*DEPTH.
    assign out_of_range = |addr[ADDR_W-1:IW+2];
    assign loading      = (state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            load_count <= '0;
            instr      <= NOP_INSTR;
            valid      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nx;
            load_count <= count_nx;
            instr      <= instr_nx;
            valid      <= valid_nx;
            fault      <= fault_nx;
        end
    end

    // The array has no reset: a reset during a load keeps the words already
    // written, and power-up contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_count[IW-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = load_count;
        instr_nx = instr;
        valid_nx = valid;
        fault_nx = fault;
        mem_we   = 1'b0;

        case (state)
            RUN: begin
                if (load_start) begin
                    state_nx = LOAD;
                    count_nx = '0;
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                    fault_nx = 1'b0;
                end else if (stall) begin
                    // Outputs hold; the producer keeps req/addr until release.
                end else if (req) begin
                    valid_nx = 1'b1;
                    if (misaligned || out_of_range) begin
                        instr_nx = NOP_INSTR;
                        fault_nx = 1'b1;
                    end else begin
                        instr_nx = mem[fetch_idx];
                        fault_nx = 1'b0;
                    end
                end else begin
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                    fault_nx = 1'b0;
                end
            end

            LOAD: begin
                instr_nx = NOP_INSTR;
                valid_nx = 1'b0;
                fault_nx = 1'b0;
                if (load_start) begin
                    count_nx = '0;
                end else begin
                    // A write in the load_done cycle still lands before exit;
                    // a full array ignores further words instead of wrapping.
                    if (load_valid && (load_count < FULL_COUNT)) begin
                        mem_we   = 1'b1;
                        count_nx = load_count + CW'(1);
                    end
                    if (load_done || (count_nx == FULL_COUNT)) begin
                        state_nx = RUN;
                    end
                end
            end

            default: begin
                state_nx = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb_instr_mem_fetch
// Directed bench for instr_mem_fetch: program loading, sequential fetch,
// fault fetches, stall hold, load overflow and reset during a load.
// Expected fetch results come from a bench-side copy of the loaded program
// and are queued when a request is driven, then popped one cycle later.
module tb_instr_mem_fetch;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              stall = 1'b0;
    logic [DATA_W-1:0] instr;
    logic              valid;
    logic              fault;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_done = 1'b0;
    logic              loading;
    logic [CW-1:0]     load_count;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic              valid;
        logic              fault;
    } exp_t;

    exp_t              sb[$];
    exp_t              last_exp;
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] prog [4];
    int                checks = 0;
    int                failures = 0;

    instr_mem_fetch #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .addr(addr),
        .stall(stall),
        .instr(instr),
        .valid(valid),
        .fault(fault),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_done(load_done),
        .loading(loading),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs just after an edge, then move to 1 time unit
    // after the next edge so outputs are sampled away from the clock.
    task automatic applyStimulus(input logic r, input logic [ADDR_W-1:0] a,
                                 input logic s, input logic ls, input logic lv,
                                 input logic [DATA_W-1:0] d, input logic ld);
        req        = r;
        addr       = a;
        stall      = s;
        load_start = ls;
        load_valid = lv;
        load_data  = d;
        load_done  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [DATA_W-1:0] i, input logic v,
                           input logic f);
        last_exp = '{instr: i, valid: v, fault: f};
        sb.push_back(last_exp);
    endtask

    task automatic pushFetch(input logic [ADDR_W-1:0] a);
        if ((a[1:0] != 2'b00) || (a >= ADDR_W'(4 * DEPTH)))
            pushExp(NOP, 1'b1, 1'b1);
        else
            pushExp(model_mem[a[$clog2(DEPTH)+1:2]], 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=no_entry expected=scoreboard_entry", tag);
        end else begin
            e = sb.pop_front();
            checkVal({tag, ".instr"}, instr, e.instr);
            checkVal({tag, ".valid"}, 32'(valid), 32'(e.valid));
            checkVal({tag, ".fault"}, 32'(fault), 32'(e.fault));
        end
    endtask

    task automatic fetchAndCheck(input logic [ADDR_W-1:0] a, input string tag);
        pushFetch(a);
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput(tag);
    endtask

    task automatic idleAndCheck(input string tag);
        pushExp(NOP, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput(tag);
    endtask

    initial begin
        prog[0] = 32'h2002_0007;
        prog[1] = 32'h2003_0004;
        prog[2] = 32'h0043_2020;
        prog[3] = 32'hAC04_0000;

        // Reset state
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("reset.instr", instr, NOP);
        checkVal("reset.valid", 32'(valid), 32'd0);
        checkVal("reset.fault", 32'(fault), 32'd0);
        checkVal("reset.loading", 32'(loading), 32'd0);
        checkVal("reset.load_count", 32'(load_count), 32'd0);
        rst = 1'b0;

        // Load the four-word program
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkVal("load.enter.loading", 32'(loading), 32'd1);
        checkVal("load.enter.count", 32'(load_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, prog[i], 1'b0);
            model_mem[i] = prog[i];
        end
        checkVal("load.mid.valid", 32'(valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkVal("load.exit.loading", 32'(loading), 32'd0);
        checkVal("load.exit.count", 32'(load_count), 32'd4);

        // Sequential fetch, back to back
        for (int i = 0; i < 4; i++)
            fetchAndCheck(ADDR_W'(4 * i), $sformatf("fetch%0d", i));
        idleAndCheck("idle1");

        // Fault fetches
        fetchAndCheck(32'd6, "fault.misaligned");
        fetchAndCheck(32'd256, "fault.range");
        fetchAndCheck(32'd252, "edge.lastword");
        idleAndCheck("idle2");

        // Stall holds the addr-4 result while addr moves to 8
        fetchAndCheck(32'd4, "stall.pre");
        for (int i = 0; i < 3; i++) begin
            sb.push_back(last_exp);
            applyStimulus(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, '0, 1'b0);
            checkOutput($sformatf("stall.hold%0d", i));
        end
        fetchAndCheck(32'd8, "stall.release");
        idleAndCheck("idle3");

        // Overflow: 64 words fill the array and auto-exit, 6 more are ignored
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
            model_mem[i] = 32'hA000_0000 + 32'(i);
        end
        checkVal("ovf.full.loading", 32'(loading), 32'd0);
        checkVal("ovf.full.count", 32'(load_count), 32'd64);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0);
        checkVal("ovf.extra.count", 32'(load_count), 32'd64);
        checkVal("ovf.extra.loading", 32'(loading), 32'd0);
        fetchAndCheck(32'd0, "ovf.word0");
        fetchAndCheck(32'd252, "ovf.word63");

        // Reset in the middle of a load after two words
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        model_mem[0] = 32'h1111_1111;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        model_mem[1] = 32'h2222_2222;
        checkVal("midrst.pre.count", 32'(load_count), 32'd2);
        load_valid = 1'b0;
        load_data  = '0;
        rst = 1'b1;
        #1;
        checkVal("midrst.loading", 32'(loading), 32'd0);
        checkVal("midrst.count", 32'(load_count), 32'd0);
        checkVal("midrst.valid", 32'(valid), 32'd0);
        checkVal("midrst.instr", instr, NOP);
        @(posedge clk);
        #1 rst = 1'b0;
        fetchAndCheck(32'd0, "midrst.word0");
        fetchAndCheck(32'd4, "midrst.word1");
        fetchAndCheck(32'd8, "midrst.word2");
        idleAndCheck("idle4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, clocked instruction memory for the IF stage of the MIPS pipeline. It replaces fixed hard-coded program tables.
- Word-addressed storage of DEPTH words. Reads are registered with a one-cycle fetch latency, a stall hold and fault detection.
- A sequential program loader (auto-incrementing pointer) fills the array from the testbench or a boot source before execution.

Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, byte-address width of fetch port
- DEPTH, 64, number of instruction words (power of two, >= 2)
- NOP_INSTR, 32'h0000_0000, value driven on instr at reset, on fault, and when nothing valid is held

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  fetch request
- addr  input  ADDR_W  fetch byte address
- stall  input  1  pipeline stall; holds fetch outputs
- instr  output  DATA_W  fetched instruction (registered)
- valid  output  1  instr/fault hold a completed fetch
- fault  output  1  completed fetch was misaligned or out of range
- load_start  input  1  enter LOAD mode; pointer cleared to 0
- load_valid  input  1  load_data is to be written at the pointer
- load_data  input  DATA_W  program word
- load_done  input  1  leave LOAD mode
- loading  output  1  high while in LOAD state
- load_count  output  $clog2(DEPTH)+1  words written since last load_start

Behaviour:
- Reset (async, immediate): state=RUN, instr=NOP_INSTR, valid=0, fault=0, load_count=0, loading=0. The memory array is not cleared; contents after power-up are undefined until loaded.
- FSM states RUN and LOAD:
  - RUN -> LOAD when load_start=1. load_count<=0, valid<=0, instr<=NOP_INSTR.
  - LOAD -> RUN when load_done=1, or on the cycle load_count reaches DEPTH.
  - load_start in LOAD restarts: load_count<=0, stays in LOAD, and takes priority over load_done.
- LOAD state:
  - loading=1. Fetch req is ignored; valid=0; instr=NOP_INSTR.
  - When load_valid=1 and load_count<DEPTH: mem[load_count]<=load_data and load_count<=load_count+1.
  - load_valid when load_count==DEPTH is ignored (no wrap, no overwrite).
  - A load_valid asserted in the same cycle as load_done is written before the exit.
- RUN state, fetch timing:
  - Word index = addr[$clog2(DEPTH)+1:2].
  - One-cycle latency: req sampled at edge N gives instr/valid/fault visible after edge N.
- RUN state, good fetch (addr[1:0]==0 and addr < 4*DEPTH): instr<=mem[index], fault<=0, valid<=1.
- RUN state, fault fetch (addr[1:0]!=0 or addr >= 4*DEPTH): instr<=NOP_INSTR, fault<=1, valid<=1.
- RUN state, req=0 and stall=0: valid<=0, fault<=0, instr<=NOP_INSTR.
- Stall: when stall=1 (RUN), instr/valid/fault hold their values and req is not accepted. The producer must hold req/addr until stall drops.
- Priority within RUN: load_start > stall > req.
- Reset mid-load: returns to RUN immediately. Words already written remain in memory; load_count=0.

Test Plan:
- Reset then load 4 words: load_start, then load_valid with 0x20020007, 0x20030004, 0x00432020, 0xAC040000, then load_done -> loading 1→0, load_count=4.
- Sequential fetch in RUN: req with addr 0,4,8,12 -> each word appears one cycle later with valid=1, fault=0, in the loaded order.
- Fault fetches: addr=6 -> instr=0, fault=1, valid=1. addr=4*DEPTH=256 -> fault=1.
- Stall: fetch addr 4, assert stall 3 cycles while addr changes to 8 -> instr holds 0x20030004 for all 3 cycles. After stall drops, the addr-8 word appears the next cycle.
- Load overflow: DEPTH=64, issue 70 load_valid pulses -> load_count saturates at 64, auto-return to RUN at that cycle, mem[0] is not overwritten.
- Reset mid-load after 2 words -> immediate RUN, valid=0, load_count=0. Fetching addr 0 and 4 returns the 2 new words.
